// File: rtl/bus_pkg.sv
// Shared definitions for the req/ack/cmd/resp bus endpoints.
package bus_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int SEL_MSB = 31;
    localparam int SEL_LSB = 30;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        ACK,
        GAP,
        RESP_WAIT
    } slv_state_t;

endpackage

// File: rtl/slave_mem.sv
// Single-port 2^ADDR_W x 32 synchronous RAM with write enable and registered read.
module slave_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset so committed writes survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_slave.sv
// Memory-backed bus responder: programmable ack delay, write commit,
// and one-cycle read response after a programmable delay.
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int ACK_LAT  = 1,
    parameter int RESP_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ack,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp,
    output logic [31:0] rdata
);

    localparam int MAX_LAT = (ACK_LAT > RESP_LAT) ? ACK_LAT : RESP_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    slv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             resp_q, resp_d;
    logic             mem_we;
    logic             mem_re;
    logic [31:0]      mem_rdata;
    logic             unused_addr;

    assign unused_addr = ^{addr[SEL_MSB:ADDR_W+2], addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (ACK_LAT == 1) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT_ACK;
                        cnt_d   = CNT_W'(ACK_LAT - 1);
                    end
                end
            end
            WAIT_ACK: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (cmd == CMD_WRITE) begin
                    mem_we  = 1'b1;
                    state_d = GAP;
                end else begin
                    mem_re  = 1'b1;
                    state_d = RESP_WAIT;
                    cnt_d   = CNT_W'(RESP_LAT - 1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            RESP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decode next state so ack/resp come straight from flops.
    assign ack_d  = (state_d == ACK);
    assign resp_d = (state_d == RESP_WAIT) && (cnt_d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
        end
    end

    slave_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (addr[ADDR_W+1:2]),
        .wdata_i(wdata),
        .rdata_o(mem_rdata)
    );

    assign ack   = ack_q;
    assign resp  = resp_q;
    assign rdata = resp_q ? mem_rdata : 32'h0;

endmodule
